// File: rtl/uart_pkg.sv
// Shared constants for the configurable UART transmitter: parity modes,
// FSM state encodings and a counter-width helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Bits needed for a counter running 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_hold.sv
// One-entry holding register between the payload handshake and the
// transmit shifter; emptied when the FSM pulls the payload.
module uart_tx_hold #(
    parameter int DATA_BITS = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_pop,
    output logic                 o_full,
    output logic [DATA_BITS-1:0] o_data
);

    logic                 full_q;
    logic [DATA_BITS-1:0] data_q;

    // Accept only when empty and pop only when full, so the two never collide.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (i_valid && !full_q) begin
            full_q <= 1'b1;
            data_q <= i_data;
        end else if (i_pop) begin
            full_q <= 1'b0;
        end
    end

    assign o_ready = !full_q;
    assign o_full  = full_q;
    assign o_data  = data_q;

endmodule

// File: rtl/uart_tx_cfg.sv
// Parameterised UART transmitter: start bit, LSB-first data, optional
// parity and one or two stop bits, paced by an external oversample tick.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS     = 8,
    parameter int TICKS_PER_BIT = 16,
    parameter int PARITY_MODE   = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_tick,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int TW = cnt_width(TICKS_PER_BIT);
    localparam int BW = cnt_width((DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 done_q;
    logic                 load;
    logic                 frame_end;
    logic                 bit_end;
    logic                 hold_full;
    logic [DATA_BITS-1:0] hold_data;

    uart_tx_hold #(.DATA_BITS(DATA_BITS)) u_hold (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_data  (i_tx_data),
        .i_valid (i_tx_valid),
        .o_ready (o_tx_ready),
        .i_pop   (load),
        .o_full  (hold_full),
        .o_data  (hold_data)
    );

    assign bit_end = i_tick && (tick_cnt == TICK_LAST);

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hold_full) begin
                    state_d = ST_START;
                    load    = 1'b1;
                end
            end
            ST_START: if (bit_end) state_d = ST_DATA;
            ST_DATA: begin
                if (bit_end && bit_cnt == DATA_LAST)
                    state_d = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (bit_end) state_d = ST_STOP;
            ST_STOP: begin
                // A queued payload chains straight into the next start bit.
                if (bit_end && bit_cnt == STOP_LAST) begin
                    frame_end = 1'b1;
                    if (hold_full) begin
                        state_d = ST_START;
                        load    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= ST_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= frame_end;

            // Ticks seen while idle or on the load edge belong to no bit period.
            if (state_q == ST_IDLE || load)
                tick_cnt <= '0;
            else if (i_tick)
                tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;

            if (state_d != state_q)
                bit_cnt <= '0;
            else if (bit_end)
                bit_cnt <= bit_cnt + 1'b1;

            if (load) begin
                shift_q <= hold_data;
                par_q   <= (^hold_data) ^ (PARITY_MODE == PAR_ODD);
            end else if (state_q == ST_DATA && bit_end) begin
                shift_q <= shift_q >> 1;
            end
        end
    end

    always_comb begin
        o_tx = 1'b1;
        case (state_q)
            ST_START:  o_tx = 1'b0;
            ST_DATA:   o_tx = shift_q[0];
            ST_PARITY: o_tx = par_q;
            default:   o_tx = 1'b1;
        endcase
    end

    assign o_busy = (state_q != ST_IDLE);
    assign o_done = done_q;

endmodule
